// File: rtl/fxp_mac_pipe.sv
// fxp_mac_pipe -- pipelined signed fixed-point multiply / multiply-accumulate.
//
// Three register stages with one shared stall signal:
//   S1 captures the operands and control bits,
//   S2 holds the full-precision signed product (Na+Nb bits, Pa+Pb fraction),
//   S3 accumulates, rounds half toward +inf to Pout fraction bits, range-checks
//      against Nout bits and registers the result.
// Latency is 3 cycles and throughput is 1 beat/cycle. When the output is held
// (out_valid && !out_ready) every stage freezes, so no beat is dropped or reordered.
//
// Ports:
//   clk, rst_n            clock (rising edge) and asynchronous active-low reset
//   in_valid / in_ready   input handshake; in_ready = !out_valid || out_ready
//   in_a, in_b            signed operands (Na.Pa and Nb.Pb formats)
//   in_mode               0 = multiply only, 1 = multiply-accumulate
//   in_clr                MAC mode only: the accumulator restarts from this product
//   out_valid / out_ready output handshake
//   out_data              signed Nout.Pout result
//   out_ovf               rounded value fell outside the Nout range
//
// Build option: define FXP_MAC_SAT_EN to saturate out_data on overflow;
// otherwise out_data wraps (low Nout bits). The accumulator itself always wraps.

module fxp_mac_pipe #(
  parameter int Na    = 24,
  parameter int Pa    = 20,
  parameter int Nb    = 16,
  parameter int Pb    = 15,
  parameter int Nout  = 24,
  parameter int Pout  = 20,
  parameter int GUARD = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [Na-1:0]   in_a,
  input  logic [Nb-1:0]   in_b,
  input  logic            in_mode,
  input  logic            in_clr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [Nout-1:0] out_data,
  output logic            out_ovf
);

  localparam int PW    = Na + Nb;
  localparam int ACC_W = Na + Nb + GUARD;
  localparam int S     = Pa + Pb - Pout;

  // Output range limits, sign-extended to the rounding width (ACC_W+1).
  localparam logic [ACC_W:0] MAXV = {{(ACC_W-Nout+2){1'b0}}, {(Nout-1){1'b1}}};
  localparam logic [ACC_W:0] MINV = {{(ACC_W-Nout+2){1'b1}}, {(Nout-1){1'b0}}};

  logic advance;

  // Stage 1
  logic          s1_v_q;
  logic [Na-1:0] s1_a_q;
  logic [Nb-1:0] s1_b_q;
  logic          s1_mode_q;
  logic          s1_clr_q;

  // Stage 2
  logic          s2_v_q;
  logic [PW-1:0] s2_prod_q;
  logic          s2_mode_q;
  logic          s2_clr_q;
  logic [PW-1:0] prod_d;
  logic [PW-1:0] a_ext;
  logic [PW-1:0] b_ext;

  // Stage 3
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;
  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] acc_sum;
  logic [ACC_W-1:0] value;
  logic [ACC_W:0]   value_x;
  logic [ACC_W:0]   rounded;
  logic             ovf_d;
  logic [Nout-1:0]  out_data_d;
  logic             out_valid_q;
  logic [Nout-1:0]  out_data_q;
  logic             out_ovf_q;

  assign advance   = !out_valid_q || out_ready;
  assign in_ready  = advance;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;

  // ---------------------------------------------------------------- S1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q    <= 1'b0;
      s1_a_q    <= '0;
      s1_b_q    <= '0;
      s1_mode_q <= 1'b0;
      s1_clr_q  <= 1'b0;
    end else if (advance) begin
      s1_v_q    <= in_valid;
      s1_a_q    <= in_a;
      s1_b_q    <= in_b;
      s1_mode_q <= in_mode;
      s1_clr_q  <= in_clr;
    end
  end

  // ---------------------------------------------------------------- S2
  // Both operands are sign-extended to the full product width so the
  // truncated PW-bit product is the exact signed result.
  always_comb begin
    a_ext  = {{Nb{s1_a_q[Na-1]}}, s1_a_q};
    b_ext  = {{Na{s1_b_q[Nb-1]}}, s1_b_q};
    prod_d = a_ext * b_ext;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v_q    <= 1'b0;
      s2_prod_q <= '0;
      s2_mode_q <= 1'b0;
      s2_clr_q  <= 1'b0;
    end else if (advance) begin
      s2_v_q    <= s1_v_q;
      s2_prod_q <= prod_d;
      s2_mode_q <= s1_mode_q;
      s2_clr_q  <= s1_clr_q;
    end
  end

  // ---------------------------------------------------------------- S3
  always_comb begin
    prod_ext = {{GUARD{s2_prod_q[PW-1]}}, s2_prod_q};
    acc_sum  = acc_q + prod_ext;
    acc_d    = acc_q;
    value    = prod_ext;
    if (s2_mode_q) begin
      value = s2_clr_q ? prod_ext : acc_sum;
      acc_d = value;
    end
    // One extra bit so adding the rounding half can never wrap.
    value_x = {value[ACC_W-1], value};
  end

  if (S > 0) begin : g_round
    localparam logic [ACC_W:0] HALF = {{ACC_W{1'b0}}, 1'b1} << (S - 1);
    assign rounded = $signed(value_x + HALF) >>> S;
  end else begin : g_noround
    assign rounded = value_x;
  end

  always_comb begin
    ovf_d = ($signed(rounded) > $signed(MAXV)) || ($signed(rounded) < $signed(MINV));
`ifdef FXP_MAC_SAT_EN
    if (ovf_d) begin
      out_data_d = rounded[ACC_W] ? {1'b1, {(Nout-1){1'b0}}} : {1'b0, {(Nout-1){1'b1}}};
    end else begin
      out_data_d = rounded[Nout-1:0];
    end
`else
    out_data_d = rounded[Nout-1:0];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
    end else if (advance) begin
      out_valid_q <= s2_v_q;
      // Bubbles leave out_data/out_ovf and the accumulator untouched.
      if (s2_v_q) begin
        acc_q      <= acc_d;
        out_data_q <= out_data_d;
        out_ovf_q  <= ovf_d;
      end
    end
  end

endmodule

// File: tb/tb_fxp_mac_pipe.sv
// Self-checking bench for fxp_mac_pipe at default parameters (S = 15).
// A plain-arithmetic model computes each result when its beat is accepted and
// queues it; one negedge process compares every delivered result in order.
// Directed beats with hand-computed literals pin the model.

module tb_fxp_mac_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_a;
  logic [15:0] in_b;
  logic        in_mode;
  logic        in_clr;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_data;
  logic        out_ovf;

  always #5 clk = ~clk;

  fxp_mac_pipe #(
    .Na(24), .Pa(20), .Nb(16), .Pb(15), .Nout(24), .Pout(20), .GUARD(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .in_clr(in_clr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ovf(out_ovf)
  );

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // ---------------------------------------------------------------- model
  typedef struct { longint data; bit ovf; } exp_t;
  exp_t   expq[$];
  longint macc = 0;

  function automatic longint wrap48(input longint x);
    return (x <<< 16) >>> 16;
  endfunction

  function automatic exp_t model(input logic [23:0] a, input logic [15:0] b,
                                 input bit mode, input bit clr);
    exp_t   e;
    longint p, v, r;
    p = longint'($signed(a)) * longint'($signed(b));
    if (!mode) v = p;
    else begin
      macc = clr ? p : wrap48(macc + p);
      v = macc;
    end
    r = (v + (64'sd1 <<< 14)) >>> 15;
    e.ovf = (r > 64'sd8388607) || (r < -64'sd8388608);
`ifdef FXP_MAC_SAT_EN
    if (e.ovf) r = (r < 0) ? -64'sd8388608 : 64'sd8388607;
`endif
    e.data = r & 64'hFFFFFF;
    return e;
  endfunction

  // ---------------------------------------------------------------- monitor
  int          accepted = 0;
  bit          prev_stall = 0;
  logic [23:0] prev_data;
  logic        prev_ovf;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      check("reset_out_valid", out_valid, 0);
      prev_stall = 0;
    end else begin
      check("in_ready_rule", in_ready, !out_valid || out_ready);
      if (prev_stall) begin
        check("stall_hold_valid", out_valid, 1);
        check("stall_hold_data", out_data, prev_data);
        check("stall_hold_ovf", out_ovf, prev_ovf);
      end
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          checks++;
          $display("FAIL unexpected_output: got 0x%0h expected no result", out_data);
        end else begin
          e = expq.pop_front();
          check("result_data", out_data, e.data);
          check("result_ovf", out_ovf, e.ovf);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_ovf   = out_ovf;
      if (in_valid && in_ready) begin
        expq.push_back(model(in_a, in_b, in_mode, in_clr));
        accepted++;
      end
    end
  end

  // ---------------------------------------------------------------- helpers
  // One beat on an idle pipe with out_ready=1; checks latency and literal result.
  task automatic direct(input logic [23:0] a, input logic [15:0] b, input bit mode,
                        input bit clr, input longint exp_d, input bit exp_o,
                        input string name);
    int n;
    @(posedge clk); #1;
    out_ready = 1; in_valid = 1; in_a = a; in_b = b; in_mode = mode; in_clr = clr;
    @(posedge clk); #1;
    in_valid = 0;
    n = 1;
    while (!out_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_latency"}, n, 3);
    check({name, "_data"}, out_data, exp_d);
    check({name, "_ovf"}, out_ovf, exp_o);
  endtask

  // Presents a beat and holds it until accepted; returns at edge+1.
  task automatic drive_hold(input logic [23:0] a, input logic [15:0] b,
                            input bit mode, input bit clr);
    bit ok;
    bit done;
    in_valid = 1; in_a = a; in_b = b; in_mode = mode; in_clr = clr;
    done = 0;
    for (int k = 0; k < 60 && !done; k++) begin
      @(negedge clk); ok = in_ready;
      @(posedge clk); #1;
      if (ok) done = 1;
    end
    if (!done) begin
      checks++;
      $display("FAIL accept_timeout: got no acceptance expected acceptance within 60 cycles");
    end
  endtask

  task automatic drain(input string name);
    out_ready = 1; in_valid = 0;
    for (int k = 0; k < 30 && expq.size() != 0; k++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    check(name, expq.size(), 0);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    logic [31:0] r;
    int          base;
    int          sent;
    bit          acc_ok;

    rst_n = 0; in_valid = 0; in_a = '0; in_b = '0; in_mode = 0; in_clr = 0;
    out_ready = 1;
    repeat (3) @(posedge clk);
    #2;
    check("reset_valid", out_valid, 0);
    check("reset_data", out_data, 0);
    check("reset_ovf", out_ovf, 0);
    rst_n = 1;
    #1;
    check("reset_in_ready", in_ready, 1);

    // Multiply and rounding
    direct(24'h180000, 16'h4000, 0, 0, 64'h0C0000, 0, "mul_basic");
    direct(24'h000001, 16'h4000, 0, 0, 64'h000001, 0, "round_half_up");
    direct(24'h000001, 16'h3FFF, 0, 0, 64'h000000, 0, "round_below_half");
    direct(24'hFFFFFF, 16'h4000, 0, 0, 64'h000000, 0, "round_neg_half");

    // MAC chain overflowing on the third beat
    direct(24'h700000, 16'h4000, 1, 1, 64'h380000, 0, "mac1");
    direct(24'h700000, 16'h4000, 1, 0, 64'h700000, 0, "mac2");
`ifdef FXP_MAC_SAT_EN
    direct(24'h700000, 16'h4000, 1, 0, 64'h7FFFFF, 1, "mac3_sat");
`else
    direct(24'h700000, 16'h4000, 1, 0, 64'hA80000, 1, "mac3_wrap");
`endif
    // Multiply-only beat between MAC beats leaves acc alone: 10.5 + 0.5 = 11.0
    direct(24'h100000, 16'h4000, 0, 0, 64'h080000, 0, "mode_switch_mul");
`ifdef FXP_MAC_SAT_EN
    direct(24'h100000, 16'h4000, 1, 0, 64'h7FFFFF, 1, "mode_switch_mac");
`else
    direct(24'h100000, 16'h4000, 1, 0, 64'hB00000, 1, "mode_switch_mac");
`endif

    // Backpressure: five beats with out_ready held low
    @(posedge clk); #1;
    out_ready = 0;
    base = accepted;
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          r = $urandom;
          drive_hold({4'h0, r[19:0]}, r[31:16], 1, (i == 0));
        end
        in_valid = 0;
      end
      begin
        repeat (6) @(posedge clk);
        #2;
        check("bp_accepted", accepted - base, 3);
        check("bp_in_ready", in_ready, 0);
        check("bp_out_valid", out_valid, 1);
        out_ready = 1;
      end
    join
    drain("bp_all_delivered");
    check("bp_total_accepted", accepted - base, 5);

    // Randomized traffic with random gaps and backpressure
    sent = 0;
    in_valid = 0;
    for (int cyc = 0; cyc < 4000 && (sent < 300 || in_valid); cyc++) begin
      @(negedge clk); acc_ok = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc_ok) begin
        in_valid = 0;
        sent++;
      end
      if (!in_valid && sent < 300 && $urandom_range(0, 3) != 0) begin
        r = $urandom;
        in_a = r[31] ? r[23:0] : {{6{r[17]}}, r[17:0]};
        r = $urandom;
        in_b = r[15:0];
        in_mode = r[16];
        in_clr = (r[19:17] == 3'd0);
        in_valid = 1;
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end
    check("random_sent", sent, 300);
    drain("random_drained");

    // Reset with three beats in flight
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      r = $urandom;
      drive_hold(r[23:0], r[31:16], 1, 0);
    end
    in_valid = 0;
    rst_n = 0;
    expq.delete();
    macc = 0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1;
    direct(24'h100000, 16'h4000, 1, 0, 64'h080000, 0, "midrst_restart");
    drain("final_drained");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion expected finish before 2 ms");
    $fatal(1);
  end

endmodule

// File: doc/fxp_mac_pipe.md
Name: fxp_mac_pipe

Overview:
- Pipelined, parametrised successor to the combinational fixed-point multiplier.
- Signed fixed-point multiply or multiply-accumulate with round-half-up, overflow detection and valid/ready handshaking on both sides.
- Sits in the DNN datapath between weight/activation fetch and the neuron output stage.
- Format notation: N total bits, P fraction bits.

Parameters:
- Na, 24, operand a width
- Pa, 20, operand a fraction bits
- Nb, 16, operand b width
- Pb, 15, operand b fraction bits
- Nout, 24, output width
- Pout, 20, output fraction bits; must satisfy Pout <= Pa+Pb
- GUARD, 8, accumulator guard bits; ACC_W = Na+Nb+GUARD

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat
- in_a  in  Na  signed operand a
- in_b  in  Nb  signed operand b
- in_mode  in  1  0 = multiply only, 1 = multiply-accumulate
- in_clr  in  1  MAC mode only: start from zero (acc = product)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  Nout  signed result
- out_ovf  out  1  this result overflowed the Nout range

Behaviour:
- Reset (async on rst_n low):
  - out_valid=0, out_data=0, out_ovf=0.
  - All stage valids=0, accumulator=0.
  - in_ready=1 once reset is released.
- Pipeline stages:
  - S1 registers a, b, mode, clr.
  - S2 registers the full signed product (Na+Nb bits, Pa+Pb fraction bits).
  - S3 accumulates, rounds, saturates/wraps, and registers the result into out_data/out_ovf/out_valid.
- Latency: 3 cycles from accepted input to out_valid with no backpressure. Throughput 1 beat/cycle.
- Handshake:
  - advance = !out_valid || out_ready.
  - in_ready = advance.
  - Input is accepted when in_valid && in_ready.
  - When advance=0, all stages hold and nothing is lost or reordered.
  - Bubbles propagate as invalid stages; they are not compressed.
  - out_data and out_ovf stay stable while out_valid && !out_ready.
- Accumulator (ACC_W bits, Pa+Pb fraction bits), updated only when a valid S2 beat advances into S3:
  - mode=0: acc unchanged; value = product.
  - mode=1, clr=1: acc = product; value = acc.
  - mode=1, clr=0: acc = acc + product (wraps at ACC_W); value = acc.
- Rounding: S = Pa+Pb-Pout.
  - If S>0: rounded = (value + 2^(S-1)) >>> S (round half toward +inf).
  - If S=0: no shift.
- Range check: the rounded value is compared to [-2^(Nout-1), 2^(Nout-1)-1]. out_ovf=1 if it lies outside.
- Output: out_data is the limited or truncated rounded value (see Optional Feature).
- Simultaneous events:
  - A new beat entering S1 while S3 outputs in the same cycle is normal flow.
  - With mode=1/clr=0 back-to-back, each beat sees the acc updated by its predecessor.
- Reset mid-operation: in-flight beats are discarded, acc is cleared, and out_valid drops immediately (asynchronously).
- The mode switch 1→0→1 without clr leaves acc intact across the multiply-only beats.

Optional Feature:
- Macro: FXP_MAC_SAT_EN.
- Defined: on overflow, out_data saturates to 2^(Nout-1)-1 or -2^(Nout-1) according to the sign of the rounded value; out_ovf=1.
- Undefined: out_data = low Nout bits of the rounded value (two's-complement wrap); out_ovf is still reported.
- Either way, acc is never saturated; only the output is.

Test Plan (default parameters, S=15):
- Basic multiply, out_ready=1: mode=0, a=0x180000 (1.5), b=0x4000 (0.5). Required: out_valid exactly 3 cycles later, out_data=0x0C0000, out_ovf=0.
- Rounding:
  - a=0x000001, b=0x4000 gives out_data=0x000001.
  - a=0x000001, b=0x3FFF gives 0x000000.
  - a=0xFFFFFF, b=0x4000 gives 0x000000.
- MAC overflow: three beats a=0x700000 (7.0), b=0x4000 (0.5), first with clr=1. Required outputs:
  - 0x380000, ovf=0
  - 0x700000, ovf=0
  - third beat, with FXP_MAC_SAT_EN: 0x7FFFFF, ovf=1
  - third beat, without the macro: 0xA80000, ovf=1
- Backpressure: hold out_ready=0 while driving 5 consecutive beats. Required:
  - in_ready drops once S3 holds a result (3 beats accepted).
  - Releasing out_ready delivers all 5 results in order with no duplicates.
- Reset mid-stream: assert rst_n=0 with 3 beats in flight, then restart mode=1, clr=0, a=0x100000, b=0x4000. Required: out_valid=0 during reset, then the next result is 0x080000 (acc restarted from 0).
